// File: rtl/ysyx_25060166_wbu_pkg.sv
// Shared constants for the RV32E writeback stage: datapath sizes,
// scoreboard counter width and the load funct3 encodings.
package ysyx_25060166_wbu_pkg;

  localparam int WBU_WIDTH   = 32;
  localparam int WBU_REG_NUM = 16;
  localparam int WBU_CNT_W   = 2;
  localparam int RD_W        = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/ysyx_25060166_load_align.sv
// Combinational load formatter: selects the byte/half lane of an aligned
// memory word and sign- or zero-extends it according to funct3.
module ysyx_25060166_load_align
  import ysyx_25060166_wbu_pkg::*;
#(
  parameter int W = WBU_WIDTH
) (
  input  logic [W-1:0] raw,
  input  logic [2:0]   funct3,
  input  logic [1:0]   off,
  output logic [W-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = raw[7:0];
    case (off)
      2'd0:    lane_b = raw[7:0];
      2'd1:    lane_b = raw[15:8];
      2'd2:    lane_b = raw[23:16];
      default: lane_b = raw[31:24];
    endcase
    // Halfword lane ignores off[0]; misaligned halves are trapped upstream.
    lane_h = off[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    data = raw;
    case (ld_funct3_e'(funct3))
      F3_LB:   data = {{(W-8){lane_b[7]}}, lane_b};
      F3_LH:   data = {{(W-16){lane_h[15]}}, lane_h};
      F3_LBU:  data = {{(W-8){1'b0}}, lane_b};
      F3_LHU:  data = {{(W-16){1'b0}}, lane_h};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_25060166_wbu.sv
// RV32E writeback stage: one-entry stage register feeding the register-file
// write port and trace commit, plus a per-register pending-write scoreboard.
module ysyx_25060166_wbu
  import ysyx_25060166_wbu_pkg::*;
#(
  parameter int WIDTH   = WBU_WIDTH,
  parameter int REG_NUM = WBU_REG_NUM,
  parameter int CNT_W   = WBU_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [RD_W-1:0]    in_rd,
  input  logic               in_rd_wen,
  input  logic               in_is_load,
  input  logic [2:0]         in_ld_funct3,
  input  logic [1:0]         in_byte_off,
  input  logic [WIDTH-1:0]   in_alu_res,
  input  logic [WIDTH-1:0]   in_load_raw,
  input  logic               issue_valid,
  input  logic [RD_W-1:0]    issue_rd,
  input  logic               issue_wen,
  output logic [REG_NUM-1:0] busy_vec,
  output logic               rf_wen,
  output logic [RD_W-1:0]    rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic               commit_valid,
  input  logic               commit_ready,
  output logic [WIDTH-1:0]   commit_pc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and a producer holds its payload
  // stable while valid is high and ready is low. in_ready may depend
  // combinationally on commit_ready so a full stage drains and refills in
  // the same cycle.
  logic               wb_valid;
  logic [WIDTH-1:0]   wb_pc;
  logic [WIDTH-1:0]   wb_data;
  logic [RD_W-1:0]    wb_rd;
  logic               wb_wen;
  logic               accept;
  logic               retire;
  logic               wb_writes;
  logic [WIDTH-1:0]   load_fmt;

  ysyx_25060166_load_align #(.W(WIDTH)) u_load_align (
    .raw    (in_load_raw),
    .funct3 (in_ld_funct3),
    .off    (in_byte_off),
    .data   (load_fmt)
  );

  assign in_ready  = !wb_valid || commit_ready;
  assign accept    = in_valid && in_ready;
  assign retire    = wb_valid && commit_ready;
  assign wb_writes = wb_wen && (wb_rd != '0);

  // Load data is formatted on entry so the stage holds only the final value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_pc    <= '0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_pc    <= in_pc;
      wb_data  <= in_is_load ? load_fmt : in_alu_res;
      wb_rd    <= in_rd;
      wb_wen   <= in_rd_wen;
    end else if (retire) begin
      wb_valid <= 1'b0;
    end
  end

  assign commit_valid = wb_valid;
  assign commit_pc    = wb_pc;
  assign rf_wen       = retire && wb_writes;
  assign rf_waddr     = wb_rd;
  assign rf_wdata     = wb_data;

  logic [REG_NUM-1:0] inc_vec;
  logic [REG_NUM-1:0] dec_vec;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_sb
    if (g == 0) begin : g_zero
      assign inc_vec[g]  = 1'b0;
      assign dec_vec[g]  = 1'b0;
      assign busy_vec[g] = 1'b0;
    end else begin : g_reg
      logic [CNT_W-1:0] cnt;

      assign inc_vec[g] = issue_valid && issue_wen && (issue_rd == RD_W'(g));
      assign dec_vec[g] = rf_wen && (wb_rd == RD_W'(g));

      // Overflow saturates and underflow holds; both are decode/protocol bugs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (inc_vec[g] && !dec_vec[g] && (cnt != CNT_MAX)) begin
          cnt <= cnt + CNT_W'(1);
        end else if (dec_vec[g] && !inc_vec[g] && (cnt != '0)) begin
          cnt <= cnt - CNT_W'(1);
        end
      end

      assign busy_vec[g] = (cnt != '0);

      a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inc_vec[g] && !dec_vec[g] && (cnt == CNT_MAX)))
        else $error("scoreboard overflow on x%0d", g);

      a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(dec_vec[g] && !inc_vec[g] && (cnt == '0)))
        else $error("scoreboard underflow on x%0d", g);
    end
  end

endmodule

// File: tb/tb_ysyx_25060166_wbu.sv
// Directed bench for the writeback stage: a driver pushes expected commits
// into a queue and an independent monitor pops and compares on each retire.
module tb_ysyx_25060166_wbu;
  import ysyx_25060166_wbu_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 1 + 5 + W;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_pc;
  logic [4:0]   in_rd;
  logic         in_rd_wen;
  logic         in_is_load;
  logic [2:0]   in_ld_funct3;
  logic [1:0]   in_byte_off;
  logic [W-1:0] in_alu_res;
  logic [W-1:0] in_load_raw;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_wen;
  logic [15:0]  busy_vec;
  logic         rf_wen;
  logic [4:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic         commit_valid;
  logic         commit_ready;
  logic [W-1:0] commit_pc;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  ysyx_25060166_wbu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_rd_wen    (in_rd_wen),
    .in_is_load   (in_is_load),
    .in_ld_funct3 (in_ld_funct3),
    .in_byte_off  (in_byte_off),
    .in_alu_res   (in_alu_res),
    .in_load_raw  (in_load_raw),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_wen    (issue_wen),
    .busy_vec     (busy_vec),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_pc    (commit_pc)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      if (commit_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: pc 0x%08h with empty expected queue", commit_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("commit_pc", commit_pc, mon_e[69:38]);
          check("rf_wen", 32'(rf_wen), 32'(mon_e[37]));
          check("rf_waddr", 32'(rf_waddr), 32'(mon_e[36:32]));
          check("rf_wdata", rf_wdata, mon_e[31:0]);
        end
      end else begin
        check("stall_rf_wen", 32'(rf_wen), 32'h0);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] pc, input logic [4:0] rd, input logic wen,
                      input logic is_load, input logic [2:0] f3, input logic [1:0] off,
                      input logic [W-1:0] alu, input logic [W-1:0] raw,
                      input logic do_issue, input logic [W-1:0] exp_data);
    logic acc;
    int n;
    in_valid     = 1'b1;
    in_pc        = pc;
    in_rd        = rd;
    in_rd_wen    = wen;
    in_is_load   = is_load;
    in_ld_funct3 = f3;
    in_byte_off  = off;
    in_alu_res   = alu;
    in_load_raw  = raw;
    issue_valid  = do_issue;
    issue_rd     = rd;
    issue_wen    = wen;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (acc) begin
      exp_q.push_back({pc, (wen && rd != 5'd0), rd, exp_data});
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pc 0x%08h never accepted", pc);
    end
  endtask

  task automatic issue_only(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_wen   = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic check_busy(input string name, input logic [15:0] exp);
    @(negedge clk);
    check(name, 32'(busy_vec), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d commits still pending", exp_q.size());
    end
  endtask

  localparam logic [W-1:0] RAW = 32'h80FF7F01;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0; in_is_load = 1'b0;
    in_ld_funct3 = '0; in_byte_off = '0; in_alu_res = '0; in_load_raw = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_wen = 1'b0; commit_ready = 1'b1;

    #2;
    check("reset_commit_valid", 32'(commit_valid), 32'h0);
    check("reset_rf_wen", 32'(rf_wen), 32'h0);
    check("reset_busy_vec", 32'(busy_vec), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    check("reset_rf_waddr", 32'(rf_waddr), 32'h0);
    check("reset_rf_wdata", rf_wdata, 32'h0);
    check("reset_commit_pc", commit_pc, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU result, one-cycle latency
    send(32'h8000_0000, 5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 1'b1, 32'h0000_1234);
    drain();
    check_busy("busy_after_alu", 16'h0000);

    // load formatting, back to back
    send(32'h8000_0010, 5'd10, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0, RAW, 1'b1, 32'hFFFF_FF80);
    send(32'h8000_0014, 5'd10, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0, RAW, 1'b1, 32'h0000_80FF);
    send(32'h8000_0018, 5'd10, 1'b1, 1'b1, 3'b001, 2'd0, 32'h0, RAW, 1'b1, 32'h0000_7F01);
    send(32'h8000_001C, 5'd10, 1'b1, 1'b1, 3'b100, 2'd1, 32'h0, RAW, 1'b1, 32'h0000_007F);
    send(32'h8000_0020, 5'd10, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, RAW, 1'b1, 32'hFFFF_80FF);
    send(32'h8000_0024, 5'd10, 1'b1, 1'b1, 3'b000, 2'd0, 32'h0, RAW, 1'b1, 32'h0000_0001);
    send(32'h8000_0028, 5'd10, 1'b1, 1'b1, 3'b101, 2'd3, 32'h0, RAW, 1'b1, 32'h0000_80FF);
    send(32'h8000_002C, 5'd10, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, RAW, 1'b1, 32'h80FF_7F01);
    send(32'h8000_0030, 5'd10, 1'b1, 1'b1, 3'b011, 2'd1, 32'h0, RAW, 1'b1, 32'h80FF_7F01);
    send(32'h8000_0034, 5'd10, 1'b1, 1'b0, 3'b000, 2'd3, 32'h0000_5A5A, RAW, 1'b1, 32'h0000_5A5A);
    drain();
    check_busy("busy_after_loads", 16'h0000);

    // backpressure: hold A for 3 cycles while B waits
    commit_ready = 1'b0;
    send(32'h0000_0100, 5'd6, 1'b1, 1'b0, 3'b000, 2'd0, 32'hAAAA_5555, 32'h0, 1'b1, 32'hAAAA_5555);
    in_valid = 1'b1; in_pc = 32'h0000_0104; in_rd = 5'd8; in_rd_wen = 1'b1; in_is_load = 1'b0;
    in_alu_res = 32'h000B_EEF0; issue_valid = 1'b1; issue_rd = 5'd8; issue_wen = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'h0);
      check("stall_commit_valid", 32'(commit_valid), 32'h1);
      check("stall_commit_pc", commit_pc, 32'h0000_0100);
      check("stall_rf_waddr", 32'(rf_waddr), 32'd6);
      check("stall_rf_wdata", rf_wdata, 32'hAAAA_5555);
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
    end
    check_busy("busy_during_stall", 16'h0140);
    commit_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back({32'h0000_0104, 1'b1, 5'd8, 32'h000B_EEF0});
    drain();
    check_busy("busy_after_stall", 16'h0000);

    // x0 write and out-of-range issue are both ignored by the scoreboard
    send(32'h0000_0200, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_DEAD, 32'h0, 1'b1, 32'h0000_DEAD);
    check_busy("busy_x0", 16'h0000);
    issue_only(5'd20);
    check_busy("busy_rd_out_of_range", 16'h0000);

    // scoreboard counting
    issue_only(5'd7);
    issue_only(5'd7);
    check_busy("busy_two_pending", 16'h0080);
    send(32'h0000_0300, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0077, 32'h0, 1'b0, 32'h0000_0077);
    @(posedge clk);
    #1;
    check_busy("busy_one_retired", 16'h0080);
    send(32'h0000_0304, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0078, 32'h0, 1'b0, 32'h0000_0078);
    @(posedge clk);
    #1;
    check_busy("busy_both_retired", 16'h0000);

    // issue and retire rd=7 on the same edge
    send(32'h0000_0310, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0701, 32'h0, 1'b1, 32'h0000_0701);
    send(32'h0000_0314, 5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_0702, 32'h0, 1'b1, 32'h0000_0702);
    check_busy("busy_same_cycle", 16'h0080);
    check_busy("busy_same_cycle_done", 16'h0000);

    // async reset mid-stall with two writes pending on x3
    issue_only(5'd3);
    issue_only(5'd3);
    commit_ready = 1'b0;
    send(32'h0000_0400, 5'd3, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_3333, 32'h0, 1'b0, 32'h0000_3333);
    check_busy("busy_before_reset", 16'h0008);
    #2;
    rst = 1'b1;
    #1;
    check("async_commit_valid", 32'(commit_valid), 32'h0);
    check("async_busy_vec", 32'(busy_vec), 32'h0);
    check("async_in_ready", 32'(in_ready), 32'h1);
    check("async_rf_wen", 32'(rf_wen), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    commit_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_rf_wen", 32'(rf_wen), 32'h0);
      check("post_reset_commit_valid", 32'(commit_valid), 32'h0);
      @(posedge clk);
      #1;
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
